// File: rtl/ram_256x16_arb.sv
// Two-requester round-robin front end for a single-port synchronous RAM.
// Clears the RAM after reset (optional), then serves one access per three cycles.
module ram_256x16_arb #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wr,
  output logic              ram_oe,
  output logic              ram_test_mode,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {StInit, StIdle, StCmd, StResp} state_e;

  localparam state_e ResetState = (INIT_ON_RESET != 0) ? StInit : StIdle;
  localparam logic   ResetBusy  = (INIT_ON_RESET != 0);

  state_e state_q, state_d;
  // Extra MSB marks the end of the sweep so all 2**ADDR_W words get written.
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              gnt_b_q, gnt_b_d;
  logic              last_b_q, last_b_d;
  logic              pick_b;
  logic              ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic              busy_q, busy_d;
  logic              ram_wr_q, ram_wr_d, ram_oe_q, ram_oe_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    gnt_b_d   = gnt_b_q;
    last_b_d  = last_b_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    rdata_d   = rdata_q;
    ram_a_d   = ram_a_q;
    ram_din_d = ram_din_q;
    ram_wr_d  = 1'b0;
    ram_oe_d  = 1'b0;
    // B wins if alone, or if both request and A was served last.
    pick_b    = req_b & (~req_a | ~last_b_q);

    unique case (state_q)
      StInit: begin
        if (!cnt_q[ADDR_W]) begin
          ram_a_d   = cnt_q[ADDR_W-1:0];
          ram_din_d = '0;
          ram_wr_d  = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (req_a || req_b) begin
          gnt_b_d   = pick_b;
          we_d      = pick_b ? we_b : we_a;
          ram_a_d   = pick_b ? addr_b : addr_a;
          ram_din_d = pick_b ? wdata_b : wdata_a;
          ram_wr_d  = we_d;
          ram_oe_d  = ~we_d;
          state_d   = StCmd;
        end
      end
      StCmd: begin
        state_d = StResp;
      end
      StResp: begin
        ack_a_d  = ~gnt_b_q;
        ack_b_d  = gnt_b_q;
        last_b_d = gnt_b_q;
        if (!we_q) rdata_d = ram_dout;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StInit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ResetState;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      gnt_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      busy_q    <= ResetBusy;
      rdata_q   <= '0;
      ram_a_q   <= '0;
      ram_din_q <= '0;
      ram_wr_q  <= 1'b0;
      ram_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      gnt_b_q   <= gnt_b_d;
      last_b_q  <= last_b_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
      ram_a_q   <= ram_a_d;
      ram_din_q <= ram_din_d;
      ram_wr_q  <= ram_wr_d;
      ram_oe_q  <= ram_oe_d;
    end
  end

  assign ack_a         = ack_a_q;
  assign ack_b         = ack_b_q;
  assign busy          = busy_q;
  assign rdata         = rdata_q;
  assign ram_a         = ram_a_q;
  assign ram_din       = ram_din_q;
  assign ram_wr        = ram_wr_q;
  assign ram_oe        = ram_oe_q;
  assign ram_test_mode = 1'b0;

endmodule

// File: tb/tb_ram_256x16_arb.sv
// Bench for ram_256x16_arb: synchronous RAM model, scoreboard of expected acks,
// one task per scenario.
module tb_ram_256x16_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [7:0]  addr_a = '0, addr_b = '0;
  logic [15:0] wdata_a = '0, wdata_b = '0;
  logic        ack_a, ack_b, busy, ram_wr, ram_oe, ram_test_mode;
  logic [15:0] rdata, ram_din;
  logic [15:0] ram_dout = '0;
  logic [7:0]  ram_a;

  always #5 clk = ~clk;

  ram_256x16_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b),
    .rdata(rdata), .busy(busy), .ram_a(ram_a), .ram_din(ram_din), .ram_wr(ram_wr),
    .ram_oe(ram_oe), .ram_test_mode(ram_test_mode), .ram_dout(ram_dout)
  );

  // Synchronous RAM with junk initial contents so the clearing sweep matters.
  logic [15:0] mem [256] = '{default: 16'hA5A5};
  always @(posedge clk) begin
    if (ram_wr) mem[ram_a] <= ram_din;
    if (ram_oe) ram_dout <= mem[ram_a];
  end

  typedef struct packed {logic is_b; logic is_rd; logic [15:0] data;} exp_t;
  exp_t        sb[$];
  logic [15:0] exp_mem [256];
  logic        exp_last_b;
  int          total = 0;
  int          bad = 0;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) exp_mem[i] = 16'h0000;
    exp_last_b = 1'b1;
    sb.delete();
  endtask

  task automatic wait_sweep();
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL sweep_end: busy=%b want 0", busy);
    end
  endtask

  task automatic access(input logic is_b, input logic we, input logic [7:0] addr,
                        input logic [15:0] data);
    exp_t e;
    int   k = 0;
    bit   got = 0;
    e.is_b  = is_b;
    e.is_rd = ~we;
    e.data  = we ? 16'h0000 : exp_mem[addr];
    if (we) exp_mem[addr] = data;
    sb.push_back(e);
    if (is_b) begin req_b = 1; we_b = we; addr_b = addr; wdata_b = data; end
    else      begin req_a = 1; we_a = we; addr_a = addr; wdata_a = data; end
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      if (ack_a === 1'b1 || ack_b === 1'b1) begin
        got = 1;
        e = sb.pop_front();
        total++;
        if (k != 3) begin bad++; $display("FAIL latency: got %0d want 3", k); end
        total++;
        if (ack_a !== ~e.is_b || ack_b !== e.is_b) begin
          bad++;
          $display("FAIL ack_who: ack_a=%b ack_b=%b want b=%b", ack_a, ack_b, e.is_b);
        end
        if (e.is_rd) begin
          total++;
          if (rdata !== e.data) begin
            bad++;
            $display("FAIL rdata @%h: got %h want %h", addr, rdata, e.data);
          end
        end
        exp_last_b = e.is_b;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout: no ack want ack within 10 cycles");
      sb.delete();
    end
    req_a = 0;
    req_b = 0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (ack_a !== 0 || ack_b !== 0) begin bad++; $display("FAIL rst_ack: got %b%b want 00", ack_a, ack_b); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
    total++; if (ram_wr !== 0 || ram_oe !== 0) begin bad++; $display("FAIL rst_wr_oe: got %b%b want 00", ram_wr, ram_oe); end
    total++; if (ram_a !== 8'h0 || ram_din !== 16'h0) begin bad++; $display("FAIL rst_ram_bus: got %h/%h want 0", ram_a, ram_din); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", busy); end
    total++; if (ram_test_mode !== 1'b0) begin bad++; $display("FAIL test_mode: got %b want 0", ram_test_mode); end
  endtask

  task automatic test_init_sweep();
    int errs = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || ram_wr !== 1'b1 || ram_a !== 8'(i) || ram_din !== 16'h0) begin
        if (errs == 0) $display("FAIL sweep_step %0d: busy=%b wr=%b a=%h want 1 1 %h", i, busy, ram_wr, ram_a, 8'(i));
        errs++;
      end
    end
    total++; if (errs != 0) bad++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ram_wr !== 1'b0) begin
      bad++;
      $display("FAIL sweep_len: busy=%b wr=%b want 0 0 after 256 cycles", busy, ram_wr);
    end
    model_reset();
    access(1'b0, 1'b0, 8'h00, 16'h0);
    access(1'b0, 1'b0, 8'hFF, 16'h0);
  endtask

  task automatic test_write_read();
    access(1'b0, 1'b1, 8'h12, 16'hBEEF);
    access(1'b0, 1'b0, 8'h12, 16'h0);
    access(1'b1, 1'b1, 8'h20, 16'h5A5A);
    access(1'b1, 1'b0, 8'h20, 16'h0);
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic nb;
    int   n = 0, acks = 0, last = 0;
    nb = ~exp_last_b;
    for (int i = 0; i < 6; i++) begin
      e.is_b = nb; e.is_rd = 1'b0; e.data = 16'h0;
      sb.push_back(e);
      nb = ~nb;
    end
    exp_mem[8'h40] = 16'h1111;
    exp_mem[8'h41] = 16'h2222;
    req_a = 1; we_a = 1; addr_a = 8'h40; wdata_a = 16'h1111;
    req_b = 1; we_b = 1; addr_b = 8'h41; wdata_b = 16'h2222;
    while (acks < 6 && n < 40) begin
      @(negedge clk);
      n++;
      total++;
      if ((ack_a === 1'b1 && ack_b === 1'b1) || (ram_wr === 1'b1 && ram_oe === 1'b1)) begin
        bad++;
        $display("FAIL exclusive: ack=%b%b wr/oe=%b%b want not both", ack_a, ack_b, ram_wr, ram_oe);
      end
      if (ack_a === 1'b1 || ack_b === 1'b1) begin
        e = sb.pop_front();
        acks++;
        total++;
        if (ack_b !== e.is_b) begin
          bad++;
          $display("FAIL rr_order #%0d: ack_b=%b want %b", acks, ack_b, e.is_b);
        end
        total++;
        if (n - last != 3) begin bad++; $display("FAIL rr_gap: got %0d want 3", n - last); end
        last = n;
        exp_last_b = e.is_b;
      end
    end
    req_a = 0;
    req_b = 0;
    total++;
    if (acks != 6) begin bad++; $display("FAIL rr_count: got %0d want 6", acks); sb.delete(); end
    access(1'b0, 1'b0, 8'h40, 16'h0);
    access(1'b1, 1'b0, 8'h41, 16'h0);
  endtask

  task automatic test_init_pending();
    int n = 0, seen = 0;
    @(negedge clk);
    rst_n = 0;
    req_b = 1; we_b = 0; addr_b = 8'h77;
    exp_mem[8'h77] = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (ack_b === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL init_pending: acks=%0d busy=%b want 0 0", seen, busy);
    end
    model_reset();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if (ack_b !== (k == 3)) begin bad++; $display("FAIL pend_ack cyc %0d: got %b want %b", k, ack_b, k == 3); end
    end
    total++;
    if (rdata !== 16'h0) begin bad++; $display("FAIL pend_rdata: got %h want 0000", rdata); end
    req_b = 0;
    exp_last_b = 1'b1;
  endtask

  task automatic test_reset_mid_cmd();
    int acks = 0;
    @(negedge clk);
    req_a = 1; we_a = 1; addr_a = 8'h50; wdata_a = 16'hCAFE;
    @(negedge clk);
    total++;
    if (ram_wr !== 1'b1 || ram_a !== 8'h50) begin
      bad++;
      $display("FAIL cmd_wr: wr=%b a=%h want 1 50", ram_wr, ram_a);
    end
    rst_n = 0;
    #1;
    total++; if (ram_wr !== 1'b0) begin bad++; $display("FAIL abort_wr: got %b want 0", ram_wr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b want 1", busy); end
    req_a = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack_a === 1'b1 || ack_b === 1'b1) acks++;
    end
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      if (ack_a === 1'b1 || ack_b === 1'b1) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("FAIL abort_ack: got %0d acks want 0", acks); end
    wait_sweep();
    model_reset();
    access(1'b0, 1'b0, 8'h50, 16'h0);
  endtask

  task automatic test_rdata_hold();
    access(1'b0, 1'b1, 8'h34, 16'h1234);
    access(1'b0, 1'b0, 8'h34, 16'h0);
    access(1'b1, 1'b1, 8'h35, 16'h5678);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rdata !== 16'h1234) begin bad++; $display("FAIL rdata_hold %0d: got %h want 1234", k, rdata); end
      @(negedge clk);
    end
    access(1'b1, 1'b0, 8'h35, 16'h0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_sweep();
    test_write_read();
    test_round_robin();
    test_init_pending();
    test_reset_mid_cmd();
    test_rdata_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_256x16_arb.md
RAM_256X16_ARB -- requirements
Module: ram_256x16_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter INIT_ON_RESET, default 1, clear all RAM words after reset when 1.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  clock, rising edge active
- rst_n  input  1  asynchronous active-low reset
- req_a  input  1  requester A access request
- we_a  input  1  requester A write (1) / read (0)
- addr_a  input  ADDR_W  requester A address
- wdata_a  input  DATA_W  requester A write data
- ack_a  output  1  requester A access complete
- req_b, we_b, addr_b, wdata_b, ack_b  same as A, for requester B
- rdata  output  DATA_W  read data, shared by both requesters
- busy  output  1  init sweep in progress
- ram_a  output  ADDR_W  RAM address
- ram_din  output  DATA_W  RAM write data
- ram_wr  output  1  RAM write strobe
- ram_oe  output  1  RAM output enable
- ram_test_mode  output  1  RAM bypass select, tied 0
- ram_dout  input  DATA_W  RAM read data

Function
REQ-005 SHALL be an FSM with states INIT, IDLE, CMD and RESP; all outputs registered except ram_test_mode.
REQ-006 INIT: ram_a = sweep counter, ram_din = 0, ram_wr = 1 each cycle; counter increments 0..255; busy = 1; leave to IDLE the cycle after address 255 is written (256 write cycles total).
REQ-007 In INIT, SHALL ignore all requests, with no ack; requests stay pending.
REQ-008 IDLE: if either req is high, pick a winner, latch its we/addr/wdata, go to CMD; otherwise stay; ram_wr = ram_oe = 0.
REQ-009 Arbitration SHALL be round-robin: a single requester wins; when both request, the requester not served last wins; after reset, A has priority.
REQ-010 CMD (1 cycle): drive ram_a/ram_din from the latched values; ram_wr = 1 if write, else ram_oe = 1; go to RESP.
REQ-011 RESP (1 cycle): pulse the winner's ack for exactly one cycle; on read, rdata <= ram_dout; on write, rdata holds; update last-served; go to IDLE.
REQ-012 Latency SHALL be req sampled in IDLE at cycle N, ack high in cycle N+3; minimum 3 cycles per access, 1/3 throughput.
REQ-013 Requesters SHALL hold req and payload until ack; changing inputs after the IDLE sample has no effect on the current access.
REQ-014 SHALL never assert ack_a and ack_b in the same cycle, nor ram_wr and ram_oe together.
REQ-015 rdata SHALL be valid from the ack cycle until the next read completes.
REQ-016 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-017 ram_test_mode SHALL be constant 0.

Reset
REQ-018 rst_n low SHALL asynchronously force: ack_a = ack_b = 0, rdata = 0, ram_wr = ram_oe = 0, ram_a = 0, ram_din = 0, sweep counter = 0, last-served = B.
REQ-019 During reset, busy SHALL be 1 if INIT_ON_RESET = 1, else 0; state SHALL be INIT or IDLE to match.
REQ-020 Reset asserted mid-access or mid-sweep SHALL abort it with no ack, and restart from REQ-018/019 on release.

Verification
REQ-021 Reset release with INIT_ON_RESET = 1 -> busy for exactly 256 cycles with ram_wr = 1 and ram_a = 0..255; then reads of addr 0x00 and 0xFF return 0x0000.
REQ-022 A writes 0xBEEF to 0x12, then A reads 0x12 -> ack_a 3 cycles after each sampled req; rdata = 0xBEEF on the second ack.
REQ-023 req_a and req_b both held high for 6 accesses -> acks in order A, B, A, B, A, B; never both high together.
REQ-024 req_b held high during the init sweep -> no ack_b until busy falls; ack_b arrives 3 cycles after the first IDLE.
REQ-025 rst_n pulsed low during a CMD cycle of a write -> no ack; ram_wr drops immediately; busy reasserts if INIT_ON_RESET = 1.
REQ-026 A read of 0x34 is followed by a B write to 0x35 -> rdata keeps the 0x34 value through and after ack_b.
